grid_bank_arbiter: RTL and testbench
====================================

// Module: grid_bank_arbiter
// PURPOSE
// - Shared grid-row memory bank plus round-robin access arbiter for NUM_REQ pruning machines.
// - Each machine owns a row band. It issues chunked read/write requests and receives a
//   one-cycle ack with data.
// - Sits directly below the machines. Serves their read_en/write_en/row/col requests and
//   drives their ack_in and partial_vec_in.
// - A host port loads and reads back the grid.
// PARAMETERS
// - NUM_REQ  4    number of machine requesters
// - DEPTH    256  rows in bank
// - ROW_W    256  bits per row (grid width padded to multiple of DATA_W)
// - DATA_W   32   chunk width per access (power of 2)
// - ROW_AW   $clog2(DEPTH)+1  row address width; one extra bit for out-of-range rows
// - COL_AW   $clog2(ROW_W)    column address width
// PORTS
// - clock         in   1                clock, rising edge
// - reset         in   1                synchronous, active-high
// - req_read_en   in   NUM_REQ          per-requester read request, held until ack
// - req_write_en  in   NUM_REQ          per-requester write request, held until ack
// - req_row_addr  in   NUM_REQ*ROW_AW   packed row address, requester i at [i*ROW_AW +: ROW_AW]
// - req_col_addr  in   NUM_REQ*COL_AW   packed column address (bit index)
// - req_wdata     in   NUM_REQ*DATA_W   packed write chunk
// - ack_out       out  NUM_REQ          one-cycle completion pulse per requester
// - rdata_out     out  DATA_W           read chunk, broadcast; valid when any ack_out or host_ack is high
// - host_en       in   1                host access request, held until host_ack
// - host_we       in   1                1 = write, 0 = read
// - host_row      in   ROW_AW           host row address
// - host_col      in   COL_AW           host column address
// - host_wdata    in   DATA_W           host write chunk
// - host_ack      out  1                one-cycle completion pulse for host
// - busy_out      out  1                access in flight (ACK state)
// BEHAVIOUR
// - Reset values:
//   - ack_out=0, host_ack=0, rdata_out=0, busy_out=0, rr_ptr=0, state=IDLE.
//   - Bank contents are not cleared. Reset mid-access drops the in-flight op; no ack is issued.
// - Addressing:
//   - chunk index = col >> log2(DATA_W). Low log2(DATA_W) bits are ignored.
//   - Chunk k maps to row bits [k*DATA_W +: DATA_W].
// - Out-of-range access: row >= DEPTH or chunk >= ROW_W/DATA_W.
//   - Still acked with normal latency.
//   - Read returns all zeros; write is dropped.
// - FSM IDLE -> ACK -> IDLE:
//   - IDLE: pick a winner; perform bank read/write at the clock edge; capture rdata; go to ACK.
//   - ACK: pulse ack for the winner with rdata_out valid; no new grant; return to IDLE.
//   - Latency: request seen in IDLE -> ack 1 cycle later.
//   - Throughput: one access per 2 cycles.
//   - The ACK gap guarantees a requester's stale request is never served twice.
// - Arbitration:
//   - host_en has strict priority over all machines.
//   - Among machines, round-robin starting at rr_ptr.
//   - On a machine grant, rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
//   - A host grant leaves rr_ptr unchanged.
//   - A requester is eligible when read_en or write_en is high.
//   - Both high: write wins and a single read is not issued.
// - Write: bank chunk replaced with wdata; rdata_out = written chunk (write-through).
// - Requests deasserted before grant are simply not served; no error.
// - Simultaneous write and read to the same chunk by different requesters: serialized by
//   grant order; a later read sees the earlier write.
// - Bank: single-port, synchronous write, registered read; inferable as block RAM.
// CONFIGURATION
// - GRID_BANK_ARB_STATS_EN defined adds:
//   - grant_cnt_out  NUM_REQ*32: per-machine grants, saturating at 2^32-1.
//   - stall_max_out  32: longest IDLE-eligible wait of any machine, in cycles.
//   - Both counters clear on reset only.
// - GRID_BANK_ARB_STATS_EN undefined: these ports and counters are absent; functional
//   behaviour is identical.
// TESTING
// - T1: host writes 0xDEADBEEF at row 3 col 32, host reads back
//   -> host_ack 1 cycle after each request; rdata_out=0xDEADBEEF.
// - T2: req 0..3 all read row 0 in the same cycle with rr_ptr=0
//   -> acks in order 0,1,2,3 on cycles 1,3,5,7; ack_out never has two bits set.
// - T3: req1 reads row DEPTH; req2 writes 0xFFFFFFFF to row DEPTH+1
//   -> both acked; rdata_out=0 for req1; bank unchanged.
// - T4: host_en and req0 asserted together
//   -> host served first (host_ack cycle 1); req0 acked cycle 3; rr_ptr unchanged by host.
// - T5: req0 writes 0x1 row 5 col 31 (chunk 0), then req1 reads row 5 col 0
//   -> req1 rdata_out=0x1.
// - T6: reset asserted in the ACK cycle of req2
//   -> ack_out=0 next cycle; rr_ptr=0; previously written rows retain data.

Source files
------------

// File: rtl/grid_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grid_bank_arbiter
// Brief    : Shared grid-row bank with host-priority / round-robin machine
//            arbiter; optional grant/stall statistics via GRID_BANK_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module grid_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 256,
    parameter int ROW_W   = 256,
    parameter int DATA_W  = 32,
    parameter int ROW_AW  = $clog2(DEPTH) + 1,
    parameter int COL_AW  = $clog2(ROW_W)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_read_en,
    input  logic [NUM_REQ-1:0]        req_write_en,
    input  logic [NUM_REQ*ROW_AW-1:0] req_row_addr,
    input  logic [NUM_REQ*COL_AW-1:0] req_col_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack_out,
    output logic [DATA_W-1:0]         rdata_out,
    input  logic                      host_en,
    input  logic                      host_we,
    input  logic [ROW_AW-1:0]         host_row,
    input  logic [COL_AW-1:0]         host_col,
    input  logic [DATA_W-1:0]         host_wdata,
    output logic                      host_ack,
    output logic                      busy_out
`ifdef GRID_BANK_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     grant_cnt_out,
    output logic [31:0]               stall_max_out
`endif
);

    localparam int NCHUNK    = ROW_W / DATA_W;
    localparam int CHUNK_SH  = $clog2(DATA_W);
    localparam int MEM_WORDS = DEPTH * NCHUNK;
    localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OUT_ZERO = 2'd0,
        OUT_MEM  = 2'd1,
        OUT_WR   = 2'd2
    } out_sel_t;

    state_t              state;
    state_t              next_state;
    out_sel_t            out_sel;

    logic [RR_W-1:0]     rr_ptr;
    logic [RR_W-1:0]     win;
    logic [RR_W-1:0]     win_next;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  ack_next;
    logic                mach_found;
    int                  scan_idx;

    logic                grant_host;
    logic                grant_mach;
    logic                grant_any;

    logic                sel_we;
    logic [ROW_AW-1:0]   sel_row;
    logic [COL_AW-1:0]   sel_col;
    logic [DATA_W-1:0]   sel_wdata;
    int                  row_i;
    int                  chunk_i;
    logic                in_range;
    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_we;
    logic                mem_re;

    // Bank stored as one chunk per word so a single-port block RAM fits directly.
    logic [DATA_W-1:0]   mem [MEM_WORDS];
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   wr_q;

    assign elig = req_read_en | req_write_en;

    // Round-robin scan starting at rr_ptr; first eligible machine wins.
    always_comb begin
        mach_found = 1'b0;
        win        = '0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!mach_found && elig[scan_idx]) begin
                mach_found = 1'b1;
                win        = RR_W'(scan_idx);
            end
        end
    end

    assign win_next = (win == RR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // Grants are suppressed under reset so an in-flight op never touches the bank.
    always_comb begin
        grant_host = (state == IDLE) && host_en && !reset;
        grant_mach = (state == IDLE) && !host_en && mach_found && !reset;
        grant_any  = grant_host || grant_mach;

        if (host_en) begin
            sel_we    = host_we;
            sel_row   = host_row;
            sel_col   = host_col;
            sel_wdata = host_wdata;
        end else begin
            sel_we    = req_write_en[win];
            sel_row   = req_row_addr[int'(win)*ROW_AW +: ROW_AW];
            sel_col   = req_col_addr[int'(win)*COL_AW +: COL_AW];
            sel_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];
        end

        row_i    = int'(sel_row);
        chunk_i  = int'(sel_col) >> CHUNK_SH;
        in_range = (row_i < DEPTH) && (chunk_i < NCHUNK);
        mem_addr = MEM_AW'(row_i * NCHUNK + chunk_i);
        mem_we   = grant_any && sel_we && in_range;
        mem_re   = grant_any && !sel_we && in_range;
    end

    always_comb begin
        ack_next = '0;
        if (grant_mach) begin
            ack_next[win] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            ack_out  <= '0;
            host_ack <= 1'b0;
            out_sel  <= OUT_ZERO;
            wr_q     <= '0;
        end else begin
            state    <= next_state;
            ack_out  <= ack_next;
            host_ack <= grant_host;
            if (grant_mach) begin
                rr_ptr <= win_next;
            end
            if (grant_any) begin
                wr_q <= sel_wdata;
                if (sel_we) begin
                    out_sel <= OUT_WR;
                end else if (in_range) begin
                    out_sel <= OUT_MEM;
                end else begin
                    out_sel <= OUT_ZERO;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= sel_wdata;
        end
        if (mem_re) begin
            rd_q <= mem[mem_addr];
        end
    end

    // Writes return the written chunk; out-of-range reads return zero.
    always_comb begin
        case (out_sel)
            OUT_MEM: rdata_out = rd_q;
            OUT_WR:  rdata_out = wr_q;
            default: rdata_out = '0;
        endcase
    end

    assign busy_out = (state == ACK);

`ifdef GRID_BANK_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] wait_flat;
    logic [31:0]           stall_max_q;
    logic [31:0]           stall_max_d;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
            logic        granted_here;
            logic [31:0] grant_cnt;
            logic [31:0] wait_cnt;

            assign granted_here = grant_mach && (win == RR_W'(g));

            // Wait counts only IDLE cycles where this machine was eligible but lost.
            always_ff @(posedge clock) begin
                if (reset) begin
                    grant_cnt <= '0;
                    wait_cnt  <= '0;
                end else begin
                    if (granted_here && (grant_cnt != 32'hFFFF_FFFF)) begin
                        grant_cnt <= grant_cnt + 32'd1;
                    end
                    if (!elig[g] || granted_here) begin
                        wait_cnt <= '0;
                    end else if ((state == IDLE) && (wait_cnt != 32'hFFFF_FFFF)) begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
            end

            assign grant_cnt_out[g*32 +: 32] = grant_cnt;
            assign wait_flat[g*32 +: 32]     = wait_cnt;
        end
    endgenerate

    always_comb begin
        stall_max_d = stall_max_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (wait_flat[k*32 +: 32] > stall_max_d) begin
                stall_max_d = wait_flat[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_max_q <= '0;
        end else begin
            stall_max_q <= stall_max_d;
        end
    end

    assign stall_max_out = stall_max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grid_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_bank_arbiter
// Brief    : Randomised self-checking bench for grid_bank_arbiter against a
//            transaction-level model of the bank and arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_bank_arbiter;

    localparam int NR     = 4;
    localparam int DEPTH  = 256;
    localparam int ROW_W  = 256;
    localparam int DW     = 32;
    localparam int ROW_AW = $clog2(DEPTH) + 1;
    localparam int COL_AW = $clog2(ROW_W);
    localparam int NCH    = ROW_W / DW;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NR-1:0]        req_read_en;
    logic [NR-1:0]        req_write_en;
    logic [NR*ROW_AW-1:0] req_row_addr;
    logic [NR*COL_AW-1:0] req_col_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        ack_out;
    logic [DW-1:0]        rdata_out;
    logic                 host_en;
    logic                 host_we;
    logic [ROW_AW-1:0]    host_row;
    logic [COL_AW-1:0]    host_col;
    logic [DW-1:0]        host_wdata;
    logic                 host_ack;
    logic                 busy_out;
`ifdef GRID_BANK_ARB_STATS_EN
    logic [NR*32-1:0]     grant_cnt_out;
    logic [31:0]          stall_max_out;
`endif

    grid_bank_arbiter #(
        .NUM_REQ (NR),
        .DEPTH   (DEPTH),
        .ROW_W   (ROW_W),
        .DATA_W  (DW),
        .ROW_AW  (ROW_AW),
        .COL_AW  (COL_AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_read_en  (req_read_en),
        .req_write_en (req_write_en),
        .req_row_addr (req_row_addr),
        .req_col_addr (req_col_addr),
        .req_wdata    (req_wdata),
        .ack_out      (ack_out),
        .rdata_out    (rdata_out),
        .host_en      (host_en),
        .host_we      (host_we),
        .host_row     (host_row),
        .host_col     (host_col),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .busy_out     (busy_out)
`ifdef GRID_BANK_ARB_STATS_EN
        ,
        .grant_cnt_out(grant_cnt_out),
        .stall_max_out(stall_max_out)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester agents: index NR is the host.
    bit   [NR:0]  pend;
    bit           a_we [NR+1];
    bit           a_re [NR+1];
    int           a_row[NR+1];
    int           a_col[NR+1];
    logic [31:0]  a_wd [NR+1];

    // Reference model: flat chunk array, rotating pointer, one-grant-then-gap rule.
    logic [31:0]  mem_m [DEPTH*NCH];
    bit           m_busy;
    bit           m_last_idle;
    int           m_rr;
    logic [NR:0]  exp_ack;
    logic [31:0]  exp_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_agent(input int i, input bit we, input bit re, input int row,
                             input int col, input logic [31:0] wd);
        pend[i]  = 1'b1;
        a_we[i]  = we;
        a_re[i]  = re;
        a_row[i] = row;
        a_col[i] = col;
        a_wd[i]  = wd;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_read_en[i]                   = pend[i] & a_re[i];
            req_write_en[i]                  = pend[i] & a_we[i];
            req_row_addr[i*ROW_AW +: ROW_AW] = ROW_AW'(a_row[i]);
            req_col_addr[i*COL_AW +: COL_AW] = COL_AW'(a_col[i]);
            req_wdata[i*DW +: DW]            = a_wd[i];
        end
        host_en    = pend[NR];
        host_we    = a_we[NR];
        host_row   = ROW_AW'(a_row[NR]);
        host_col   = COL_AW'(a_col[NR]);
        host_wdata = a_wd[NR];
    endtask

    // Decide what the DUT must grant at the coming edge, from the driven requests.
    task automatic decide();
        int w;
        int idx;
        exp_ack     = '0;
        m_last_idle = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
            return;
        end
        w = -1;
        if (pend[NR]) begin
            w = NR;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int j = (m_rr + k) % NR;
                if (w < 0 && pend[j]) w = j;
            end
        end
        if (w < 0) begin
            m_last_idle = 1'b1;
            return;
        end
        m_busy     = 1'b1;
        exp_ack[w] = 1'b1;
        if (w < NR) m_rr = (w + 1) % NR;
        idx = a_row[w] * NCH + a_col[w] / DW;
        if (a_we[w]) begin
            if (a_row[w] < DEPTH) mem_m[idx] = a_wd[w];
            exp_data = a_wd[w];
        end else begin
            exp_data = (a_row[w] < DEPTH) ? mem_m[idx] : 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        check_eq("ack_out",    ack_out,            exp_ack[NR-1:0]);
        check_eq("host_ack",   host_ack,           exp_ack[NR]);
        check_eq("busy_out",   busy_out,           |exp_ack);
        check_eq("ack_onehot", $onehot0(ack_out),  1);
        if (|exp_ack) check_eq("rdata_out", rdata_out, exp_data);
        for (int i = 0; i <= NR; i++) begin
            if (exp_ack[i]) pend[i] = 1'b0;
        end
    endtask

    task automatic commit(input bit rnd);
        int r;
        if (rnd) begin
            for (int i = 0; i <= NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range((i == NR) ? 7 : 2) == 0) begin
                        r = $urandom_range(3);
                        set_agent(i, (i == NR) ? 1'($urandom_range(1)) : (r == 1 || r == 2),
                                  (r != 1),
                                  ($urandom_range(9) == 0) ? DEPTH + $urandom_range(DEPTH-1)
                                  : (($urandom_range(1) == 0) ? $urandom_range(7)
                                                              : $urandom_range(DEPTH-1)),
                                  $urandom_range(ROW_W-1), $urandom);
                    end
                end else if ($urandom_range(19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        drive();
        decide();
    endtask

    // Only valid when the previous decision was an idle no-grant.
    task automatic launch();
        drive();
        decide();
    endtask

    task automatic drain();
        int n = 0;
        while (!(pend == '0 && m_last_idle) && n < 200) begin
            tick();
            commit(1'b0);
            n++;
        end
        check_eq("drain_timeout", (n < 200), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst_ack_out",  ack_out,   0);
        check_eq("rst_host_ack", host_ack,  0);
        check_eq("rst_busy",     busy_out,  0);
        check_eq("rst_rdata",    rdata_out, 0);
        pend        = '0;
        drive();
        reset       = 1'b0;
        m_busy      = 1'b0;
        m_rr        = 0;
        exp_ack     = '0;
        m_last_idle = 1'b1;
    endtask

    initial begin
        pend = '0;
        for (int i = 0; i <= NR; i++) begin
            a_we[i] = 1'b0; a_re[i] = 1'b0; a_row[i] = 0; a_col[i] = 0; a_wd[i] = '0;
        end
        drive();
        do_reset();
        do_reset();

        // Known contents everywhere so every later read has a defined expectation.
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < NCH; c++) begin
                set_agent(NR, 1'b1, 1'b0, r, c*DW + $urandom_range(DW-1), $urandom);
                launch();
                drain();
            end
        end

        // Host write then read-back at row 3 col 32.
        set_agent(NR, 1'b1, 1'b0, 3, 32, 32'hDEAD_BEEF); launch(); drain();
        set_agent(NR, 1'b0, 1'b0, 3, 32, 32'h0);         launch(); drain();
        check_eq("t1_model", mem_m[3*NCH + 1], 32'hDEAD_BEEF);

        // All four machines read row 0 together.
        for (int i = 0; i < NR; i++) set_agent(i, 1'b0, 1'b1, 0, $urandom_range(ROW_W-1), '0);
        launch(); drain();

        // Out-of-range read and write; row DEPTH+1 col 0 must not alias onto row 1.
        set_agent(1, 1'b0, 1'b1, DEPTH,     0, 32'h0);
        set_agent(2, 1'b1, 1'b0, DEPTH + 1, 0, 32'hFFFF_FFFF);
        launch(); drain();
        set_agent(NR, 1'b0, 1'b0, 1, 0, 32'h0); launch(); drain();

        // Host priority, and host grants leave the rotating pointer alone.
        set_agent(NR, 1'b0, 1'b0, 7, 64, 32'h0);
        set_agent(0,  1'b0, 1'b1, 8, 0,  32'h0);
        launch(); drain();
        set_agent(NR, 1'b0, 1'b0, 9, 0, 32'h0);
        set_agent(0,  1'b0, 1'b1, 9, 32, 32'h0);
        set_agent(1,  1'b1, 1'b1, 9, 32, 32'h1234_5678);
        launch(); drain();

        // Write by one machine is visible to the next reader of the same chunk.
        set_agent(0, 1'b1, 1'b0, 5, 31, 32'h1); launch(); drain();
        set_agent(1, 1'b0, 1'b1, 5, 0,  32'h0); launch(); drain();
        check_eq("t5_model", mem_m[5*NCH], 32'h1);

        // Reset during req2's ACK cycle; pointer returns to 0, bank retained.
        set_agent(2, 1'b0, 1'b1, 5, 0, 32'h0); launch();
        tick();
        do_reset();
        for (int i = 0; i < NR; i++) set_agent(i, 1'b0, 1'b1, 5, 0, '0);
        launch(); drain();

        // Reset landing on the grant edge drops the write.
        set_agent(3, 1'b1, 1'b0, 10, 64, 32'hA5A5_5A5A);
        drive();
        do_reset();
        set_agent(NR, 1'b0, 1'b0, 10, 64, 32'h0); launch(); drain();

        repeat (3000) begin
            tick();
            commit(1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
